hazard_control_unit: RTL and testbench

//  Pipeline hazard controller. Consumes the ID_EX stage outputs and the IF_ID source fields, and drives stall/flush controls back into the PC, IF_ID and ID_EX registers.

---
 rtl/hazard_control_unit.sv | 117 +++++++++++
 tb/tb_hazard_control_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Load-use / redirect hazard controller: Mealy stall and flush controls for the
// PC, IF_ID and ID_EX registers, plus saturating debug event counters.
module hazard_control_unit #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_rs1_i,
  input  logic [4:0]       IF_ID_rs2_i,
  input  logic             IF_ID_uses_rs1_i,
  input  logic             IF_ID_uses_rs2_i,
  input  logic             ID_EX_mem_read_i,
  input  logic             ID_EX_reg_write_i,
  input  logic [4:0]       ID_EX_write_register_i,
  input  logic             EX_branch_taken_i,
  input  logic             EX_jalr_i,
  output logic             pc_write_o,
  output logic             IF_ID_write_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_bubble_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic             MULTI    = (STALL_CYCLES > 1);
  localparam logic [2:0]       REM_INIT = 3'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t     r_state;
  logic [2:0] r_rem;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_rs1_match;
  logic w_rs2_match;
  logic w_hz;
  logic w_redir;

  assign w_rs1_match = IF_ID_uses_rs1_i && (IF_ID_rs1_i == ID_EX_write_register_i);
  assign w_rs2_match = IF_ID_uses_rs2_i && (IF_ID_rs2_i == ID_EX_write_register_i);
  // A load into x0 produces no value, so it can never be a hazard source.
  assign w_hz = ID_EX_mem_read_i && ID_EX_reg_write_i &&
                (ID_EX_write_register_i != 5'd0) && (w_rs1_match || w_rs2_match);
  assign w_redir = EX_branch_taken_i || EX_jalr_i;

  // NOTE: every output gets a default before the branches; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    pc_write_o     = 1'b1;
    IF_ID_write_o  = 1'b1;
    IF_ID_flush_o  = 1'b0;
    ID_EX_bubble_o = 1'b0;
    if (!reset) begin
      pc_write_o     = 1'b0;
      IF_ID_write_o  = 1'b0;
      IF_ID_flush_o  = 1'b1;
      ID_EX_bubble_o = 1'b1;
    end else if (w_redir) begin
      // A redirect squashes the stalled instruction anyway, so it wins in both states.
      IF_ID_flush_o  = 1'b1;
      ID_EX_bubble_o = 1'b1;
    end else if (r_state == STALL || w_hz) begin
      pc_write_o     = 1'b0;
      IF_ID_write_o  = 1'b0;
      ID_EX_bubble_o = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_rem   <= 3'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (MULTI && !w_redir && w_hz) begin
            r_state <= STALL;
            r_rem   <= REM_INIT;
          end
        end
        STALL: begin
          if (w_redir || r_rem <= 3'd1) begin
            r_state <= RUN;
            r_rem   <= 3'd0;
          end else begin
            r_rem <= r_rem - 3'd1;
          end
        end
        default: begin
          r_state <= RUN;
          r_rem   <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_write_o && r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (IF_ID_flush_o && r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign busy_o      = (r_state == STALL);
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: a combinational vector table plus
// hand-written multi-cycle sequences on four differently parameterised copies.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, rw, br, jalr;

  logic a_pcw, a_ifw, a_fl, a_bb, a_busy;
  logic [15:0] a_sc, a_fc;
  logic b_pcw, b_ifw, b_fl, b_bb, b_busy;
  logic [1:0] b_sc, b_fc;
  logic c_pcw, c_ifw, c_fl, c_bb, c_busy;
  logic [15:0] c_sc, c_fc;
  logic d_pcw, d_ifw, d_fl, d_bb, d_busy;
  logic [15:0] d_sc, d_fc;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.STALL_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .IF_ID_rs1_i(rs1), .IF_ID_rs2_i(rs2),
    .IF_ID_uses_rs1_i(u1), .IF_ID_uses_rs2_i(u2), .ID_EX_mem_read_i(mr),
    .ID_EX_reg_write_i(rw), .ID_EX_write_register_i(rd), .EX_branch_taken_i(br),
    .EX_jalr_i(jalr), .pc_write_o(a_pcw), .IF_ID_write_o(a_ifw), .IF_ID_flush_o(a_fl),
    .ID_EX_bubble_o(a_bb), .busy_o(a_busy), .stall_cnt_o(a_sc), .flush_cnt_o(a_fc));

  hazard_control_unit #(.STALL_CYCLES(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .IF_ID_rs1_i(rs1), .IF_ID_rs2_i(rs2),
    .IF_ID_uses_rs1_i(u1), .IF_ID_uses_rs2_i(u2), .ID_EX_mem_read_i(mr),
    .ID_EX_reg_write_i(rw), .ID_EX_write_register_i(rd), .EX_branch_taken_i(br),
    .EX_jalr_i(jalr), .pc_write_o(b_pcw), .IF_ID_write_o(b_ifw), .IF_ID_flush_o(b_fl),
    .ID_EX_bubble_o(b_bb), .busy_o(b_busy), .stall_cnt_o(b_sc), .flush_cnt_o(b_fc));

  hazard_control_unit #(.STALL_CYCLES(3), .CNT_W(16)) dut_c (
    .clk(clk), .reset(reset), .IF_ID_rs1_i(rs1), .IF_ID_rs2_i(rs2),
    .IF_ID_uses_rs1_i(u1), .IF_ID_uses_rs2_i(u2), .ID_EX_mem_read_i(mr),
    .ID_EX_reg_write_i(rw), .ID_EX_write_register_i(rd), .EX_branch_taken_i(br),
    .EX_jalr_i(jalr), .pc_write_o(c_pcw), .IF_ID_write_o(c_ifw), .IF_ID_flush_o(c_fl),
    .ID_EX_bubble_o(c_bb), .busy_o(c_busy), .stall_cnt_o(c_sc), .flush_cnt_o(c_fc));

  hazard_control_unit #(.STALL_CYCLES(4), .CNT_W(16)) dut_d (
    .clk(clk), .reset(reset), .IF_ID_rs1_i(rs1), .IF_ID_rs2_i(rs2),
    .IF_ID_uses_rs1_i(u1), .IF_ID_uses_rs2_i(u2), .ID_EX_mem_read_i(mr),
    .ID_EX_reg_write_i(rw), .ID_EX_write_register_i(rd), .EX_branch_taken_i(br),
    .EX_jalr_i(jalr), .pc_write_o(d_pcw), .IF_ID_write_o(d_ifw), .IF_ID_flush_o(d_fl),
    .ID_EX_bubble_o(d_bb), .busy_o(d_busy), .stall_cnt_o(d_sc), .flush_cnt_o(d_fc));

  // exp packs {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble}
  typedef struct {
    logic       mr, rw;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, br, jalr;
    logic [3:0] exp;
  } vec_t;

  localparam logic [3:0] O_RUN   = 4'b1100;
  localparam logic [3:0] O_STALL = 4'b0001;
  localparam logic [3:0] O_FLUSH = 4'b1111;
  localparam logic [3:0] O_RESET = 4'b0011;

  vec_t vecs[11];

  function automatic vec_t mk(logic m, logic w, logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                              logic e1, logic e2, logic b, logic j, logic [3:0] e);
    vec_t v;
    v.mr = m; v.rw = w; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.u1 = e1; v.u2 = e2; v.br = b; v.jalr = j; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    mr = 0; rw = 0; rd = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; br = 0; jalr = 0;
  endtask

  task automatic set_hz();
    set_idle();
    mr = 1; rw = 1; rd = 5'd5; rs1 = 5'd5; u1 = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    reset = 0;
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stall_seen;
    int busy_seen;

    vecs[0]  = mk(0, 1, 5,  5,  0, 1, 0, 0, 0, O_RUN);    // not a load
    vecs[1]  = mk(1, 1, 5,  5,  0, 1, 0, 0, 0, O_STALL);  // rs1 load-use
    vecs[2]  = mk(1, 1, 5,  5,  0, 0, 0, 0, 0, O_RUN);    // rs1 not read
    vecs[3]  = mk(1, 1, 5,  0,  5, 0, 1, 0, 0, O_STALL);  // rs2 load-use
    vecs[4]  = mk(1, 1, 0,  0,  0, 1, 1, 0, 0, O_RUN);    // rd == x0
    vecs[5]  = mk(1, 0, 5,  5,  5, 1, 1, 0, 0, O_RUN);    // load without writeback
    vecs[6]  = mk(1, 1, 7,  6,  8, 1, 1, 0, 0, O_RUN);    // no register match
    vecs[7]  = mk(1, 1, 5,  5,  0, 1, 0, 1, 0, O_FLUSH);  // branch beats hazard
    vecs[8]  = mk(0, 0, 0,  0,  0, 0, 0, 0, 1, O_FLUSH);  // jalr alone
    vecs[9]  = mk(1, 1, 31, 0, 31, 0, 1, 0, 0, O_STALL);  // highest register
    vecs[10] = mk(1, 1, 31, 3, 31, 1, 0, 0, 0, O_RUN);    // match on unused rs2

    // Reset state and outputs while reset is held low
    set_idle();
    #2;
    check("reset_outputs", {a_pcw, a_ifw, a_fl, a_bb}, O_RESET);
    check("reset_busy", d_busy, 0);
    check("reset_cnts", {a_sc, a_fc}, 0);
    @(negedge clk);
    reset = 1;

    // Combinational vector table on the single-bubble copy
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      mr = vecs[i].mr; rw = vecs[i].rw; rd = vecs[i].rd;
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; u1 = vecs[i].u1; u2 = vecs[i].u2;
      br = vecs[i].br; jalr = vecs[i].jalr;
      #1;
      check($sformatf("vec%0d", i), {a_pcw, a_ifw, a_fl, a_bb}, vecs[i].exp);
    end

    // T1: single-cycle stall
    do_reset();
    set_hz();
    #1;
    check("t1_stall", {a_pcw, a_bb}, 2'b01);
    @(negedge clk);
    set_idle();
    #1;
    check("t1_release", {a_pcw, a_bb}, 2'b10);
    check("t1_stall_cnt", a_sc, 1);

    // T2: three-cycle stall, busy for the two cycles after the hazard
    do_reset();
    set_hz();
    stall_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (!c_pcw) stall_seen++;
      if (c_busy) busy_seen++;
      @(negedge clk);
      set_idle();
    end
    check("t2_stall_cycles", stall_seen, 3);
    check("t2_busy_cycles", busy_seen, 2);
    check("t2_stall_cnt", c_sc, 3);
    check("t2_back_to_run", {c_busy, c_pcw}, 2'b01);

    // T3: load to x0 with matching rs1 never stalls
    do_reset();
    set_hz();
    rd = 0; rs1 = 0;
    #1;
    check("t3_pc_write", a_pcw, 1);
    @(negedge clk);
    check("t3_stall_cnt", a_sc, 0);

    // T4: branch coincident with a hazard
    do_reset();
    set_hz();
    br = 1;
    #1;
    check("t4_outputs", {a_pcw, a_fl, a_bb}, 3'b111);
    @(negedge clk);
    set_idle();
    check("t4_flush_cnt", a_fc, 1);
    check("t4_stall_cnt", a_sc, 0);

    // T5: flush counter saturates at 3 with CNT_W=2
    do_reset();
    jalr = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) check("t5_flush_cnt_2", b_fc, 2);
    end
    set_idle();
    check("t5_flush_sat", b_fc, 3);

    // Redirect during STALL ends the stall early
    do_reset();
    set_hz();
    @(negedge clk);
    set_idle();
    br = 1;
    #1;
    check("stall_redir_busy", d_busy, 1);
    check("stall_redir_out", {d_pcw, d_ifw, d_fl, d_bb}, O_FLUSH);
    @(negedge clk);
    set_idle();
    #1;
    check("stall_redir_run", {d_busy, d_pcw}, 2'b01);

    // T6: reset asserted in the second stall cycle of a 4-cycle stall
    do_reset();
    set_hz();
    @(negedge clk);
    set_idle();
    #1;
    check("t6_in_stall", {d_busy, d_pcw}, 2'b10);
    check("t6_cnt_before", d_sc, 1);
    #1;
    reset = 0;
    #1;
    check("t6_async_cnts", {d_sc, d_fc}, 0);
    check("t6_async_busy", d_busy, 0);
    check("t6_reset_out", {d_pcw, d_ifw, d_fl, d_bb}, O_RESET);
    @(negedge clk);
    reset = 1;
    #1;
    check("t6_after_release", {d_busy, d_pcw, d_bb}, 3'b010);
    @(negedge clk);
    check("t6_next_cycle", {d_busy, d_pcw, d_sc}, {1'b0, 1'b1, 16'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
